b_resp_rx: RTL and testbench

B_RESP_RX -- requirements
Module: b_resp_rx

---
 rtl/b_resp_rx.sv | 144 ++++++++++++++
 tb/tb_b_resp_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/b_resp_rx.sv
// Write-response receiver: buffers B responses in a FWFT FIFO, tracks outstanding
// writes, counts error responses and flags unexpected, overflow and timeout events.
module b_resp_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             BVALID,
  input  logic [1:0]                       BRESP,
  output logic                             BREADY,
  input  logic                             WISSUE,
  output logic                             RSP_VALID,
  output logic [1:0]                       RSP_DATA,
  input  logic                             RSP_READY,
  output logic [$clog2(MAX_OUT+1)-1:0]     OUTSTANDING,
  output logic [7:0]                       ERR_COUNT,
  output logic                             UNEXP,
  output logic                             ISSUE_OVF,
  output logic                             TIMEOUT,
  input  logic                             CLR_FLAGS
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [15:0] TMR_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TOUT} state_t;

  logic [1:0]    mem_reg [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [OW-1:0] out_reg, out_next;
  logic [7:0]    err_count_reg;
  logic          unexp_reg, ovf_reg, timeout_reg;
  logic [15:0]   timer_reg;
  state_t        state_reg;
  logic          hs, pop, ovf_set, err_set;

  assign BREADY      = (count_reg != CW'(FIFO_DEPTH));
  assign RSP_VALID   = (count_reg != '0);
  assign RSP_DATA    = RSP_VALID ? mem_reg[rd_ptr_reg] : 2'b00;
  assign hs          = BVALID && BREADY;
  assign pop         = RSP_VALID && RSP_READY;
  assign err_set     = hs && BRESP[1];
  assign OUTSTANDING = out_reg;
  assign ERR_COUNT   = err_count_reg;
  assign UNEXP       = unexp_reg;
  assign ISSUE_OVF   = ovf_reg;
  assign TIMEOUT     = timeout_reg;

  // Storage carries no reset: empty/full is decided purely by count_reg.
  always_ff @(posedge clk) begin
    if (hs) mem_reg[wr_ptr_reg] <= BRESP;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (hs)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({hs, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A simultaneous issue and response cancel out, even at the saturation limits.
  always_comb begin
    out_next = out_reg;
    ovf_set  = 1'b0;
    if (WISSUE && !hs) begin
      if (out_reg == OW'(MAX_OUT)) ovf_set  = 1'b1;
      else                         out_next = out_reg + OW'(1);
    end else if (hs && !WISSUE && out_reg != '0) begin
      out_next = out_reg - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_reg       <= '0;
      err_count_reg <= '0;
      unexp_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      out_reg <= out_next;
      if (CLR_FLAGS)                          err_count_reg <= err_set ? 8'd1 : 8'd0;
      else if (err_set && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      if (hs && out_reg == '0) unexp_reg <= 1'b1;
      else if (CLR_FLAGS)      unexp_reg <= 1'b0;
      if (ovf_set)             ovf_reg   <= 1'b1;
      else if (CLR_FLAGS)      ovf_reg   <= 1'b0;
    end
  end

  // Timeout watchdog; a later assignment to timeout_reg overrides the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (CLR_FLAGS) timeout_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          timer_reg <= '0;
          if (out_next != '0) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (out_next == '0) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
          end else if (hs) begin
            timer_reg <= '0;
          end else if (timer_reg == TMR_LIMIT) begin
            state_reg   <= S_TOUT;
            timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        S_TOUT: begin
          if (hs) begin
            timer_reg <= '0;
            state_reg <= (out_next != '0) ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          timer_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b_resp_rx.sv
// Bench for b_resp_rx: directed scenarios plus random traffic, all outputs compared
// every cycle against a queue/arithmetic model of the receiver.
module tb_b_resp_rx;
  localparam int FD  = 4;
  localparam int MO  = 4;
  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       BVALID = 1'b0, WISSUE = 1'b0, RSP_READY = 1'b0, CLR_FLAGS = 1'b0;
  logic [1:0] BRESP = 2'b00;
  logic       BREADY, RSP_VALID, UNEXP, ISSUE_OVF, TIMEOUT;
  logic [1:0] RSP_DATA;
  logic [$clog2(MO+1)-1:0] OUTSTANDING;
  logic [7:0] ERR_COUNT;

  int checks = 0;
  int failures = 0;

  b_resp_rx #(.FIFO_DEPTH(FD), .MAX_OUT(MO), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .WISSUE(WISSUE), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_READY(RSP_READY),
    .OUTSTANDING(OUTSTANDING), .ERR_COUNT(ERR_COUNT), .UNEXP(UNEXP),
    .ISSUE_OVF(ISSUE_OVF), .TIMEOUT(TIMEOUT), .CLR_FLAGS(CLR_FLAGS)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [1:0] m_q[$];
  int  m_out, m_err, m_age;
  bit  m_unexp, m_ovf, m_tmo, m_stall;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_out = 0; m_err = 0; m_age = 0;
      m_unexp = 0; m_ovf = 0; m_tmo = 0; m_stall = 0;
    end else begin
      bit hs;
      int old, nxt;
      hs  = BVALID && (m_q.size() < FD);
      old = m_out;
      if (RSP_READY && m_q.size() > 0) void'(m_q.pop_front());
      if (hs) m_q.push_back(BRESP);
      if (CLR_FLAGS) begin m_err = 0; m_unexp = 0; m_ovf = 0; m_tmo = 0; end
      if (hs && BRESP[1] && m_err < 255) m_err++;
      if (hs && old == 0) m_unexp = 1;
      nxt = old + (WISSUE ? 1 : 0) - (hs ? 1 : 0);
      if (nxt < 0) nxt = 0;
      if (nxt > MO) begin nxt = MO; m_ovf = 1; end
      m_out = nxt;
      if (m_out == 0 || hs) begin m_age = 0; m_stall = 0; end
      else if (old == 0) m_age = 0;
      else if (!m_stall) begin
        m_age++;
        if (m_age == TMO) begin m_stall = 1; m_tmo = 1; end
      end
    end
  end

  always @(negedge clk) begin
    check("bready",    BREADY,      (m_q.size() < FD));
    check("rsp_valid", RSP_VALID,   (m_q.size() > 0));
    check("rsp_data",  RSP_DATA,    (m_q.size() > 0) ? m_q[0] : 2'b00);
    check("outstanding", OUTSTANDING, m_out);
    check("err_count", ERR_COUNT,   m_err);
    check("unexp",     UNEXP,       m_unexp);
    check("issue_ovf", ISSUE_OVF,   m_ovf);
    check("timeout",   TIMEOUT,     m_tmo);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    BVALID = 0; WISSUE = 0; CLR_FLAGS = 0; RSP_READY = 0; BRESP = 2'b00;
  endtask

  initial begin
    logic [1:0] codes [3];
    codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11;
    cyc(2);
    check("reset_bready", BREADY, 1);
    check("reset_out", OUTSTANDING, 0);
    resetn = 1;

    // Three writes, responses OKAY/SLVERR/DECERR streamed straight through
    WISSUE = 1; cyc(3); WISSUE = 0;
    check("lit_out3", OUTSTANDING, 3);
    RSP_READY = 1; BVALID = 1;
    BRESP = 2'b00; cyc(1); check("lit_d0", RSP_DATA, 0);  check("lit_out2", OUTSTANDING, 2);
    BRESP = 2'b10; cyc(1); check("lit_d1", RSP_DATA, 2);
    BRESP = 2'b11; cyc(1); check("lit_d2", RSP_DATA, 3);
    check("lit_out0", OUTSTANDING, 0); check("lit_err2", ERR_COUNT, 2);
    BVALID = 0; cyc(1); check("lit_empty", RSP_VALID, 0);

    // Fill buffer, back-pressure, single pop releases one slot
    RSP_READY = 0; WISSUE = 1; cyc(4); WISSUE = 0;
    BVALID = 1; BRESP = 2'b00; cyc(4);
    check("lit_full_bready", BREADY, 0);
    cyc(3);
    check("lit_held_bready", BREADY, 0);
    RSP_READY = 1; cyc(1); RSP_READY = 0;
    check("lit_pop_bready", BREADY, 1);
    cyc(1);
    check("lit_refill_bready", BREADY, 0);
    check("lit_unexp_5th", UNEXP, 1);
    BVALID = 0; RSP_READY = 1; cyc(6);
    CLR_FLAGS = 1; cyc(1); CLR_FLAGS = 0;

    // Unexpected response
    RSP_READY = 0; BVALID = 1; BRESP = 2'b10; cyc(1); BVALID = 0;
    check("lit_unexp", UNEXP, 1); check("lit_unexp_out", OUTSTANDING, 0);
    check("lit_unexp_buf", RSP_DATA, 2);
    CLR_FLAGS = 1; cyc(1); CLR_FLAGS = 0;
    check("lit_unexp_clr", UNEXP, 0);
    RSP_READY = 1; cyc(2);

    // Timeout after TMO cycles waiting, late response returns to idle
    WISSUE = 1; cyc(1); WISSUE = 0;
    cyc(TMO - 1); check("lit_tmo_before", TIMEOUT, 0);
    cyc(1);       check("lit_tmo_at", TIMEOUT, 1);
    cyc(5);
    BVALID = 1; cyc(1); BVALID = 0;
    check("lit_tmo_late_out", OUTSTANDING, 0); check("lit_tmo_sticky", TIMEOUT, 1);
    CLR_FLAGS = 1; cyc(1); CLR_FLAGS = 0;
    check("lit_tmo_clr", TIMEOUT, 0);

    // Issue overflow at MAX_OUT; simultaneous issue+response is not overflow
    RSP_READY = 0; WISSUE = 1; cyc(4);
    check("lit_ovf_pre", ISSUE_OVF, 0);
    cyc(1); WISSUE = 0;
    check("lit_ovf", ISSUE_OVF, 1); check("lit_ovf_out", OUTSTANDING, 4);
    CLR_FLAGS = 1; cyc(1); CLR_FLAGS = 0;
    WISSUE = 1; BVALID = 1; cyc(1); WISSUE = 0; BVALID = 0;
    check("lit_both_out", OUTSTANDING, 4); check("lit_both_ovf", ISSUE_OVF, 0);

    // Reset mid-operation
    RSP_READY = 1; cyc(2); RSP_READY = 0;
    BVALID = 1; cyc(1); WISSUE = 1; cyc(1); WISSUE = 0;
    check("lit_pre_rst_out", OUTSTANDING, 3);
    #2 resetn = 0;
    #1;
    check("rst_bready", BREADY, 1);    check("rst_valid", RSP_VALID, 0);
    check("rst_data", RSP_DATA, 0);    check("rst_out", OUTSTANDING, 0);
    check("rst_err", ERR_COUNT, 0);    check("rst_unexp", UNEXP, 0);
    check("rst_ovf", ISSUE_OVF, 0);    check("rst_tmo", TIMEOUT, 0);
    cyc(2); resetn = 1; BVALID = 0;
    cyc(1); check("lit_post_rst_valid", RSP_VALID, 0);

    // Error counter saturation, and clear coinciding with an error
    RSP_READY = 1; BVALID = 1; BRESP = 2'b11; cyc(260);
    check("lit_err_sat", ERR_COUNT, 255);
    CLR_FLAGS = 1; cyc(1); CLR_FLAGS = 0; BVALID = 0;
    check("lit_err_clr_set", ERR_COUNT, 1);
    cyc(2);

    // Random traffic in blocks, some with responses suppressed to provoke timeouts
    for (int blk = 0; blk < 80; blk++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 30; c++) begin
        WISSUE    = ($urandom_range(0, 2) == 0);
        BVALID    = (mode != 0) && ($urandom_range(0, 1) == 1);
        BRESP     = codes[$urandom_range(0, 2)];
        RSP_READY = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        CLR_FLAGS = ($urandom_range(0, 24) == 0);
        cyc(1);
      end
    end
    idle_inputs();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
